hdmi_rx_capture: RTL and testbench

Receive-side counterpart of the 16-bit HDMI transmit path. Samples an external parallel video bus carrying RGB565 (clock-aligned pixel, de, hs, vs) and expands each pixel to RGB888. Delivers pixels as a 24-bit AXI4-Stream with start-of-frame (tuser) and end-of-line (tlast) markers. Sits between an HDMI receiver chip's parallel outputs and a VDMA/stream consumer in the PL.

---
 rtl/hdmi_rx_capture.sv | 123 ++++++++++++
 tb/tb_hdmi_rx_capture.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hdmi_rx_capture.sv
// hdmi_rx_capture: RGB565 parallel video bus -> RGB888 AXI4-Stream with tuser (SOF) / tlast (EOL)
// Ports: clk/resetn (sync, active-low), enable; vid_data/vid_de/vid_hs/vid_vs video input;
//        m_axis_* 24-bit stream out; ovf sticky overflow with ovf_clr; line_width/frame_height status.
// Optional: define HDMI_RX_CAPTURE_MEASURE_EN to build the line/frame measurement counters.
module hdmi_rx_capture #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter bit VS_ACTIVE_HIGH = 1'b1,
  parameter int LINE_CNT_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic [15:0]               vid_data,
  input  logic                      vid_de,
  input  logic                      vid_hs,
  input  logic                      vid_vs,
  output logic [23:0]               m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [LINE_CNT_WIDTH-1:0] line_width,
  output logic [LINE_CNT_WIDTH-1:0] frame_height
);
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;
  state_t state;
  logic [15:0] d1;
  logic de1, hs1, vs1, vs1_d;
  logic [23:0] hold_data;
  logic hold_valid, hold_sof, sof_pending;
  logic [25:0] mem [2**FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0] count;
  logic vs_edge, push, full, wr, rd;
  logic [23:0] rgb;
  assign rgb = {d1[15:11], d1[15:13], d1[10:5], d1[10:9], d1[4:0], d1[4:2]};
  assign vs_edge = vs1 & ~vs1_d;
  // count never exceeds the depth, so its MSB alone marks full
  assign full = count[FIFO_DEPTH_LOG2];
  assign push = hold_valid & enable;
  assign wr = push & ~full;
  assign rd = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = count != '0;
  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = m_axis_tvalid ? mem[rd_ptr] : '0;
  // the hold pixel ends a line when the sample behind it has no de, or a new frame starts
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {hold_data, hold_sof, ~de1 | vs_edge};
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      d1 <= '0;
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      vs1_d <= 1'b0;
      hold_data <= '0;
      hold_valid <= 1'b0;
      hold_sof <= 1'b0;
      sof_pending <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      d1 <= vid_data;
      de1 <= vid_de;
      hs1 <= vid_hs;
      vs1 <= VS_ACTIVE_HIGH ? vid_vs : ~vid_vs;
      vs1_d <= vs1;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_DEPTH_LOG2{1'b0}}, wr} - {{FIFO_DEPTH_LOG2{1'b0}}, rd};
      ovf <= (push & full) | (ovf & ~ovf_clr);
      hold_valid <= 1'b0;
      if (!enable) state <= IDLE;
      else if (push & full) state <= SYNC;
      else if (state == IDLE) state <= SYNC;
      else if (state == SYNC) begin
        if (vs_edge) begin
          state <= ACTIVE;
          sof_pending <= 1'b1;
        end
      end else if (de1) begin
        hold_data <= rgb;
        hold_valid <= 1'b1;
        hold_sof <= sof_pending | vs_edge;
        sof_pending <= 1'b0;
      end else if (vs_edge) sof_pending <= 1'b1;
    end
  end
`ifdef HDMI_RX_CAPTURE_MEASURE_EN
  logic de1_d;
  logic [LINE_CNT_WIDTH-1:0] pix_cnt, line_cnt;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      de1_d <= 1'b0;
      pix_cnt <= '0;
      line_cnt <= '0;
      line_width <= '0;
      frame_height <= '0;
    end else begin
      de1_d <= de1;
      if (state == IDLE) begin
        pix_cnt <= '0;
        line_cnt <= '0;
      end else begin
        pix_cnt <= de1 ? pix_cnt + {{(LINE_CNT_WIDTH-1){1'b0}}, ~&pix_cnt} : '0;
        if (de1_d & ~de1) line_width <= pix_cnt;
        if (vs_edge) begin
          frame_height <= line_cnt;
          line_cnt <= '0;
        end else if (de1_d & ~de1) line_cnt <= line_cnt + {{(LINE_CNT_WIDTH-1){1'b0}}, ~&line_cnt};
      end
    end
  end
`else
  assign line_width = '0;
  assign frame_height = '0;
`endif
endmodule

// File: tb/tb_hdmi_rx_capture.sv
// tb_hdmi_rx_capture: directed bench for hdmi_rx_capture
module tb_hdmi_rx_capture;
`ifdef HDMI_RX_CAPTURE_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn, enable, vid_de, vid_hs, vid_vs, m_axis_tready, ovf_clr;
  logic [15:0] vid_data;
  logic [23:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, ovf;
  logic [11:0] line_width, frame_height;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [25:0] bq[$];
  int bc[$];
  logic [15:0] pat [5];
  logic [23:0] expv [5];
  hdmi_rx_capture dut (
    .clk(clk), .resetn(resetn), .enable(enable), .vid_data(vid_data), .vid_de(vid_de),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .ovf(ovf), .ovf_clr(ovf_clr), .line_width(line_width), .frame_height(frame_height)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      bq.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      bc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic [15:0] d);
    vid_data = d;
    vid_de = 1'b1;
    step();
  endtask
  task automatic blank(input int n);
    vid_data = 16'h0;
    vid_de = 1'b0;
    repeat (n) step();
  endtask
  task automatic line(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) pix(d);
    blank(4);
  endtask
  task automatic vsync();
    vid_vs = 1'b1;
    blank(2);
    vid_vs = 1'b0;
    blank(3);
  endtask
  initial begin
    int c0;
    pat = '{16'h07E0, 16'h001F, 16'h8410, 16'hFFFF, 16'h0000};
    expv = '{24'h00FF00, 24'h0000FF, 24'h848284, 24'hFFFFFF, 24'h000000};
    resetn = 1'b0; enable = 1'b0; vid_data = 16'h0; vid_de = 1'b0; vid_hs = 1'b0;
    vid_vs = 1'b0; m_axis_tready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_lw", line_width, 0);
    chk("rst_fh", frame_height, 0);
    resetn = 1'b1; enable = 1'b1; m_axis_tready = 1'b1;
    blank(3);
    line(8, 16'hF800);
    blank(4);
    chk("pre_vs_beats", bq.size(), 0);
    vsync();
    c0 = cyc;
    for (int l = 0; l < 4; l++) line(8, 16'hF800);
    blank(6);
    chk("frameA_beats", bq.size(), 32);
    if (bq.size() == 32) begin
      chk("frameA_latency", bc[0], c0 + 3);
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("frameA_tdata%0d", i), bq[i][25:2], 24'hFF0000);
        chk($sformatf("frameA_tuser%0d", i), bq[i][1], i == 0);
        chk($sformatf("frameA_tlast%0d", i), bq[i][0], i % 8 == 7);
      end
    end
    vsync();
    chk("frameA_lw", line_width, MEAS ? 8 : 0);
    chk("frameA_fh", frame_height, MEAS ? 4 : 0);
    bq.delete(); bc.delete();
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 10; i++) pix(pat[i % 5]);
      blank(4);
    end
    blank(6);
    chk("frameB_beats", bq.size(), 50);
    if (bq.size() == 50)
      for (int i = 0; i < 50; i++) begin
        chk($sformatf("frameB_tdata%0d", i), bq[i][25:2], expv[i % 5]);
        chk($sformatf("frameB_tuser%0d", i), bq[i][1], i == 0);
        chk($sformatf("frameB_tlast%0d", i), bq[i][0], i % 10 == 9);
      end
    vsync();
    chk("frameB_lw", line_width, MEAS ? 10 : 0);
    chk("frameB_fh", frame_height, MEAS ? 5 : 0);
    bq.delete(); bc.delete();
    m_axis_tready = 1'b0;
    vsync();
    line(32, 16'h001F);
    line(8, 16'h001F);
    line(8, 16'h001F);
    chk("ovf_set", ovf, 1);
    chk("ovf_hold_tvalid", m_axis_tvalid, 1);
    chk("ovf_hold_tdata", m_axis_tdata, 24'h0000FF);
    chk("ovf_hold_tuser", m_axis_tuser, 1);
    chk("ovf_hold_tlast", m_axis_tlast, 0);
    m_axis_tready = 1'b1;
    blank(24);
    chk("ovf_beats", bq.size(), 16);
    if (bq.size() == 16) begin
      chk("ovf_beat0_tuser", bq[0][1], 1);
      chk("ovf_beat15_tdata", bq[15][25:2], 24'h0000FF);
      chk("ovf_beat15_tlast", bq[15][0], 0);
    end
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    bq.delete(); bc.delete();
    vsync();
    line(4, 16'h07E0);
    blank(4);
    chk("resume_beats", bq.size(), 4);
    if (bq.size() == 4) begin
      chk("resume_tuser0", bq[0][1], 1);
      chk("resume_tuser1", bq[1][1], 0);
      chk("resume_tdata", bq[0][25:2], 24'h00FF00);
      chk("resume_tlast3", bq[3][0], 1);
    end
    m_axis_tready = 1'b0;
    vsync();
    line(8, 16'hF800);
    pix(16'hF800); pix(16'hF800); pix(16'hF800);
    chk("half_full_tvalid", m_axis_tvalid, 1);
    chk("pre_rst_lw", line_width, MEAS ? 8 : 0);
    resetn = 1'b0;
    pix(16'hF800);
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_lw", line_width, 0);
    chk("midrst_fh", frame_height, 0);
    resetn = 1'b1;
    m_axis_tready = 1'b1;
    bq.delete(); bc.delete();
    for (int i = 0; i < 4; i++) pix(16'hF800);
    blank(4);
    line(8, 16'hF800);
    blank(4);
    chk("postrst_no_beats", bq.size(), 0);
    vsync();
    line(3, 16'h8410);
    blank(4);
    chk("postrst_beats", bq.size(), 3);
    if (bq.size() == 3) begin
      chk("postrst_tuser0", bq[0][1], 1);
      chk("postrst_tdata", bq[1][25:2], 24'h848284);
      chk("postrst_tlast2", bq[2][0], 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
